// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_ctrl_pkg;

    typedef logic [31:0] word_t;

    localparam int MU_LAT_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mu_state_t;

    // Stage hold/kill bundle handed to the pipeline stage registers.
    typedef struct packed {
        logic stopf;
        logic stopd;
        logic stope;
        logic stopm;
        logic flushd;
        logic flushe;
    } hazard_ctl_t;

    function automatic logic [31:0] reg_onehot(input logic [4:0] idx);
        return 32'(1) << idx;
    endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// rtl/hazard_ctrl_scoreboard.sv - pending-write scoreboard for long-latency producers
module hazard_ctrl_scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       set_en,
    input  logic [4:0] set_idx,
    input  logic       clr_en,
    input  logic [4:0] clr_idx,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_busy
);

    logic [31:0] sb_q;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] sb_nxt;

    always_comb begin
        set_mask = (set_en && set_idx != 5'd0) ? reg_onehot(set_idx) : 32'd0;
        clr_mask = clr_en ? reg_onehot(clr_idx) : 32'd0;
        // Clearing first lets a same-cycle set on the same register survive.
        sb_nxt   = (sb_q & ~clr_mask) | set_mask;
        sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q <= 32'd0;
        end else begin
            sb_q <= sb_nxt;
        end
    end

    assign rs1_busy = (rs1 != 5'd0) && sb_q[rs1];
    assign rs2_busy = (rs2 != 5'd0) && sb_q[rs2];
    assign rd_busy  = (rd  != 5'd0) && sb_q[rd];

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - central stall/flush controller, multicycle sequencer and redirect latch
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MU_LAT = MU_LAT_DEFAULT
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [4:0] d_rs1,
    input  logic [4:0] d_rs2,
    input  logic [4:0] d_rd,
    input  logic       d_regwrite,
    input  logic       d_longlat,
    input  logic       e_valid,
    input  logic       e_multi,
    input  logic       branch,
    input  word_t      branch_tgt,
    input  logic       m_stall,
    input  logic       f_ready,
    input  logic       wb_valid,
    input  logic       wb_regwrite,
    input  logic [4:0] wb_dst,
    output logic       stopf,
    output logic       stopd,
    output logic       stope,
    output logic       stopm,
    output logic       flushd,
    output logic       flushe,
    output logic       mu_start,
    output logic       mu_capture,
    output logic       redirect_valid,
    output word_t      redirect_pc
);

    mu_state_t   state_q;
    mu_state_t   state_nxt;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_nxt;
    logic        mu_go;
    logic        fsm_hold;
    logic        hazard;
    logic        issue;
    logic        honoured;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    hazard_ctl_t ctl;

    assign issue = d_valid & ~ctl.stopd & ~branch;

    hazard_ctrl_scoreboard u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue & d_regwrite & d_longlat),
        .set_idx  (d_rd),
        .clr_en   (wb_valid & wb_regwrite),
        .clr_idx  (wb_dst),
        .rs1      (d_rs1),
        .rs2      (d_rs2),
        .rd       (d_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    assign hazard = d_valid & (rs1_busy | rs2_busy | (d_regwrite & rd_busy));
    assign mu_go  = e_valid & e_multi & ~m_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mu_go) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 4'(MU_LAT - 1);
                end
            end
            BUSY: begin
                cnt_nxt = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!m_stall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mu_start   = 1'b0;
        mu_capture = 1'b0;
        fsm_hold   = 1'b0;
        case (state_q)
            IDLE: begin
                mu_start = mu_go;
                fsm_hold = e_valid & e_multi;
            end
            BUSY: fsm_hold = 1'b1;
            DONE: begin
                mu_capture = 1'b1;
                fsm_hold   = m_stall;
            end
            default: fsm_hold = 1'b0;
        endcase
    end

    // A branch seen while E is held is re-presented later, so it is not acted on now.
    always_comb begin
        ctl.stopm  = m_stall;
        ctl.stope  = m_stall | fsm_hold;
        ctl.stopd  = ctl.stope | hazard;
        ctl.stopf  = ctl.stopd;
        ctl.flushd = branch & ~ctl.stope;
        ctl.flushe = (branch | hazard) & ~ctl.stope;
    end

    assign honoured = branch & ~ctl.stope;

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (honoured) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= branch_tgt;
        end else if (f_ready) begin
            redirect_valid <= 1'b0;
        end
    end

    assign stopf  = ctl.stopf;
    assign stopd  = ctl.stopd;
    assign stope  = ctl.stope;
    assign stopm  = ctl.stopm;
    assign flushd = ctl.flushd;
    assign flushe = ctl.flushe;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed-vector bench for hazard_ctrl
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        d_valid = 1'b0, d_regwrite = 1'b0, d_longlat = 1'b0;
    logic [4:0]  d_rs1 = '0, d_rs2 = '0, d_rd = '0, wb_dst = '0;
    logic        e_valid = 1'b0, e_multi = 1'b0, branch = 1'b0, m_stall = 1'b0;
    logic        f_ready = 1'b0, wb_valid = 1'b0, wb_regwrite = 1'b0;
    word_t       branch_tgt = '0;
    logic        stopf, stopd, stope, stopm, flushd, flushe;
    logic        mu_start, mu_capture, redirect_valid;
    word_t       redirect_pc;
    logic [8:0]  outs;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MU_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
        .d_regwrite(d_regwrite), .d_longlat(d_longlat),
        .e_valid(e_valid), .e_multi(e_multi),
        .branch(branch), .branch_tgt(branch_tgt),
        .m_stall(m_stall), .f_ready(f_ready),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_dst(wb_dst),
        .stopf(stopf), .stopd(stopd), .stope(stope), .stopm(stopm),
        .flushd(flushd), .flushe(flushe),
        .mu_start(mu_start), .mu_capture(mu_capture),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // {stopf,stopd,stope,stopm,flushd,flushe,mu_start,mu_capture,redirect_valid}
    assign outs = {stopf, stopd, stope, stopm, flushd, flushe, mu_start, mu_capture, redirect_valid};

    // Overwriting a pending redirect is illegal by construction.
    always @(negedge clk) begin
        if (!reset && branch && !stope && redirect_valid && !f_ready) begin
            $display("FAIL redirect_overwrite: pending redirect overwritten at %0t", $time);
            miscompares++;
        end
    end

    task automatic idle_inputs();
        d_valid = 0; d_regwrite = 0; d_longlat = 0; d_rs1 = 0; d_rs2 = 0; d_rd = 0;
        e_valid = 0; e_multi = 0; branch = 0; branch_tgt = '0; m_stall = 0;
        f_ready = 0; wb_valid = 0; wb_regwrite = 0; wb_dst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); idle_inputs(); reset = 1;
        @(negedge clk); reset = 0; #1;
        vectors++;
        if (outs !== 9'b0) begin
            $display("FAIL reset_outs: got %b want %b", outs, 9'b0); miscompares++;
        end
        vectors++;
        if (redirect_pc !== 32'h0) begin
            $display("FAIL reset_pc: got %h want %h", redirect_pc, 32'h0); miscompares++;
        end
        vectors++;
        if (dut.state_q !== IDLE || dut.cnt_q !== 4'd0 || dut.u_sb.sb_q !== 32'd0) begin
            $display("FAIL reset_state: state %0d cnt %0d sb %h want 0 0 0",
                     dut.state_q, dut.cnt_q, dut.u_sb.sb_q);
            miscompares++;
        end
    endtask

    task automatic test_raw();
        logic [8:0] exp [0:5] = '{9'b000_000_000, 9'b110_001_000, 9'b110_001_000,
                                  9'b110_001_000, 9'b000_000_000, 9'b000_000_000};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); idle_inputs();
            case (c)
                0: begin d_valid = 1; d_rd = 5; d_regwrite = 1; d_longlat = 1; end
                1: begin d_valid = 1; d_rs1 = 5; end
                2: begin d_valid = 1; d_rs2 = 5; end
                3: begin d_valid = 1; d_rs1 = 5; wb_valid = 1; wb_regwrite = 1; wb_dst = 5; end
                4: begin d_valid = 1; d_rs1 = 5; end
                default: begin d_valid = 1; d_rs1 = 0; d_rd = 0; d_regwrite = 1; d_longlat = 1; end
            endcase
            #1;
            vectors++;
            if (outs !== exp[c]) begin
                $display("FAIL raw_c%0d: got %b want %b", c, outs, exp[c]); miscompares++;
            end
        end
        vectors++;
        if (dut.u_sb.sb_q !== 32'd0) begin
            $display("FAIL raw_sb_clear: got %h want %h", dut.u_sb.sb_q, 32'd0); miscompares++;
        end
    endtask

    task automatic test_set_wins_waw();
        logic [8:0] exp [0:2] = '{9'b000_000_000, 9'b110_001_000, 9'b000_000_000};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); idle_inputs();
            case (c)
                0: begin d_valid = 1; d_rd = 9; d_regwrite = 1; d_longlat = 1;
                         wb_valid = 1; wb_regwrite = 1; wb_dst = 9; end
                1: begin d_valid = 1; d_rd = 9; d_regwrite = 1;
                         wb_valid = 1; wb_regwrite = 1; wb_dst = 9; end
                default: ;
            endcase
            #1;
            vectors++;
            if (outs !== exp[c]) begin
                $display("FAIL setwins_waw_c%0d: got %b want %b", c, outs, exp[c]); miscompares++;
            end
        end
    endtask

    task automatic test_multicycle();
        logic [8:0] exp [0:5] = '{9'b111_000_100, 9'b111_000_000, 9'b111_000_000,
                                  9'b111_000_000, 9'b000_000_010, 9'b000_000_000};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); idle_inputs();
            if (c < 5) begin e_valid = 1; e_multi = 1; end
            #1;
            vectors++;
            if (outs !== exp[c]) begin
                $display("FAIL multicycle_c%0d: got %b want %b", c, outs, exp[c]); miscompares++;
            end
        end
    endtask

    task automatic test_done_stall();
        logic [8:0] exp [0:8] = '{9'b111_000_100, 9'b111_000_000, 9'b111_000_000,
                                  9'b111_000_000, 9'b111_100_010, 9'b111_100_010,
                                  9'b111_100_010, 9'b000_000_010, 9'b000_000_000};
        for (int c = 0; c < 9; c++) begin
            @(negedge clk); idle_inputs();
            if (c < 8) begin e_valid = 1; e_multi = 1; end
            if (c >= 4 && c <= 6) m_stall = 1;
            #1;
            vectors++;
            if (outs !== exp[c]) begin
                $display("FAIL done_stall_c%0d: got %b want %b", c, outs, exp[c]); miscompares++;
            end
            if (c == 6) begin
                vectors++;
                if (dut.state_q !== DONE) begin
                    $display("FAIL done_stall_state: got %0d want %0d", dut.state_q, DONE); miscompares++;
                end
            end
        end
        vectors++;
        if (dut.state_q !== IDLE) begin
            $display("FAIL done_stall_idle: got %0d want %0d", dut.state_q, IDLE); miscompares++;
        end
    endtask

    task automatic test_branch();
        logic [8:0] exp [0:3] = '{9'b000_011_000, 9'b000_000_001, 9'b000_000_001, 9'b000_000_000};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); idle_inputs();
            if (c == 0) begin branch = 1; branch_tgt = 32'h8000_0100; end
            if (c == 2) f_ready = 1;
            #1;
            vectors++;
            if (outs !== exp[c]) begin
                $display("FAIL branch_c%0d: got %b want %b", c, outs, exp[c]); miscompares++;
            end
            if (c == 1) begin
                vectors++;
                if (redirect_pc !== 32'h8000_0100) begin
                    $display("FAIL branch_pc: got %h want %h", redirect_pc, 32'h8000_0100); miscompares++;
                end
            end
        end
    endtask

    task automatic test_branch_mstall();
        logic [8:0] exp [0:3] = '{9'b111_100_000, 9'b000_011_000, 9'b000_000_001, 9'b000_000_000};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); idle_inputs();
            if (c == 0) begin branch = 1; branch_tgt = 32'h0000_2468; m_stall = 1; end
            if (c == 1) begin branch = 1; branch_tgt = 32'h0000_2468; end
            if (c == 2) f_ready = 1;
            #1;
            vectors++;
            if (outs !== exp[c]) begin
                $display("FAIL branch_mstall_c%0d: got %b want %b", c, outs, exp[c]); miscompares++;
            end
            if (c == 2) begin
                vectors++;
                if (redirect_pc !== 32'h0000_2468) begin
                    $display("FAIL branch_mstall_pc: got %h want %h", redirect_pc, 32'h0000_2468); miscompares++;
                end
            end
        end
    endtask

    task automatic test_reset_busy();
        @(negedge clk); idle_inputs();
        d_valid = 1; d_rd = 7; d_regwrite = 1; d_longlat = 1;
        @(negedge clk); idle_inputs(); e_valid = 1; e_multi = 1;
        @(negedge clk); idle_inputs(); e_valid = 1; e_multi = 1; #1;
        vectors++;
        if (dut.state_q !== BUSY || dut.u_sb.sb_q !== 32'h0000_0080) begin
            $display("FAIL pre_reset: state %0d sb %h want %0d %h",
                     dut.state_q, dut.u_sb.sb_q, BUSY, 32'h0000_0080);
            miscompares++;
        end
        @(negedge clk); idle_inputs(); reset = 1;
        @(negedge clk); reset = 0; #1;
        vectors++;
        if (outs !== 9'b0 || dut.state_q !== IDLE || dut.u_sb.sb_q !== 32'd0) begin
            $display("FAIL reset_busy: outs %b state %0d sb %h want 0 %0d 0",
                     outs, dut.state_q, dut.u_sb.sb_q, IDLE);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if (mu_start !== 1'b0 || dut.state_q !== IDLE) begin
            $display("FAIL reset_busy_restart: mu_start %b state %0d want 0 %0d",
                     mu_start, dut.state_q, IDLE);
            miscompares++;
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_raw();
        test_set_wins_waw();
        test_multicycle();
        test_done_stall();
        test_branch();
        test_branch_mstall();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It owns a register scoreboard for long-latency producers (loads, multicycle ops), sequences the fixed-latency multicycle execute unit, and latches branch redirects until fetch accepts them. All stage hold and kill signals come from this block, so no stage derives its own stall from neighbouring stages.

## Interface
Parameters:
- MU_LAT, 4, multicycle unit latency in cycles from `mu_start` to result valid; legal range 2..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- d_valid  in  1  decode slot holds a real instruction.
- d_rs1, d_rs2  in  5  decode source registers.
- d_rd  in  5  decode destination register.
- d_regwrite  in  1  decode instruction writes `d_rd`.
- d_longlat  in  1  decode instruction is a load or multicycle op.
- e_valid  in  1  execute slot holds a real instruction.
- e_multi  in  1  execute instruction uses the multicycle unit.
- branch  in  1  execute resolved a taken branch or jump this cycle.
- branch_tgt  in  word_t  redirect target.
- m_stall  in  1  memory stage waiting on the dmem handshake.
- f_ready  in  1  fetch accepts a redirect this cycle.
- wb_valid, wb_regwrite  in  1  writeback commits a register write.
- wb_dst  in  5  writeback destination.
- stopf, stopd, stope, stopm  out  1  hold the respective stage register.
- flushd, flushe  out  1  load a bubble into the D and E stage registers.
- mu_start  out  1  launch the multicycle unit.
- mu_capture  out  1  multicycle result valid; E latches it.
- redirect_valid  out  1  pending redirect toward fetch.
- redirect_pc  out  word_t  redirect target.

## Operation
- Scoreboard: 32 pending bits. Bit 0 is never set.
  - issue = d_valid & ~stopd & ~branch.
  - On issue with d_regwrite & d_longlat & d_rd≠0, set sb[d_rd].
  - When wb_valid & wb_regwrite, clear sb[wb_dst].
  - If a set and a clear hit the same bit in one cycle, the set wins.
- RAW/WAW hazard (combinational): d_valid & ((rs1≠0 & sb[rs1]) | (rs2≠0 & sb[rs2]) | (d_regwrite & d_rd≠0 & sb[d_rd])). Single-cycle ALU producers are not tracked; they are covered by forwarding.
- Multicycle FSM, with a 4-bit down-counter `cnt`:
  - IDLE: if e_valid & e_multi & ~m_stall, assert mu_start, load cnt = MU_LAT−1, go to BUSY.
  - BUSY: decrement cnt. When cnt==1, go to DONE.
  - DONE: assert mu_capture. If ~m_stall, go to IDLE; otherwise stay in DONE.
  - fsm_hold = (IDLE & e_valid & e_multi) | BUSY | (DONE & m_stall).
- Stall and flush equations:
  - stopm = m_stall.
  - stope = m_stall | fsm_hold.
  - stopd = stope | hazard.
  - stopf = stopd.
  - flushd = branch & ~stope.
  - flushe = (branch | hazard) & ~stope.
- Branch handling: branch is honoured only when ~stope; it is ignored while E is held, because E re-presents it.
- Redirect latch: an honoured branch sets redirect_valid and captures redirect_pc. redirect_valid clears on the cycle f_ready is high. A new honoured branch while a redirect is pending overwrites it; this is illegal by construction and flagged by a bench assertion.

## Timing
- Reset values: all outputs 0, scoreboard all 0, FSM IDLE, cnt 0, redirect_pc 0.
- Reset mid-operation abandons any BUSY/DONE sequence; mu_start is not re-issued.
- stop*/flush* are combinational from the inputs and registered state, in the same cycle.
- A multicycle instruction occupies E for MU_LAT+1 cycles when m_stall is low. mu_capture occurs exactly MU_LAT cycles after mu_start.
- A dependent instruction in D issues the cycle after the producer's writeback, because the pending bit clears at that edge.
- The redirect reaches fetch one cycle after branch. redirect_valid stays high at least one cycle.

## Structure
- Package `pipes` gains the `hazard_ctl_t` struct, bundling the stop and flush bits for stage wiring, and the `mu_state_t` enum {IDLE, BUSY, DONE}.
- Package `common` gains MU_LAT_DEFAULT.
- One sub-module: `scoreboard`, holding the 32-bit pending vector, the set/clear ports, and the two read lookups plus the WAW lookup.

## Test plan
- Load to x5 issues, next instruction reads x5 → stopd=1, flushe=1 until the wb_dst=5 commit; the dependent instruction issues the following cycle and sb[5]=0.
- Multicycle op in E, MU_LAT=4, m_stall=0 → mu_start in cycle 0, stope high cycles 0–3, mu_capture in cycle 4, E advances after cycle 4.
- m_stall=1 during DONE for 3 cycles → mu_capture and stope held for 3 extra cycles; the FSM stays in DONE, then returns to IDLE.
- branch=1, branch_tgt=0x8000_0100 with f_ready=0 for 2 cycles → flushd=flushe=1 for one cycle; redirect_valid=1 with redirect_pc=0x8000_0100 until f_ready, then 0.
- branch with m_stall=1 → flushd=0, no redirect captured; when m_stall drops, the flush and redirect occur.
- Reset asserted while the FSM is in BUSY with sb[7]=1 → next cycle all outputs 0, FSM IDLE, sb all 0.
